fp32_matmul_sequencer: RTL and testbench
========================================

Name: fp32_matmul_sequencer

Overview:
Hardware sequencer that replaces the bench-driven stimulus loop for the [N,16] x [16,N] FP32 matrix product.
- On start, issues every (row i of A, column j of B) pair to FP32Vector16Multiplier, one pair per cycle, fully pipelined.
- Tracks in-flight pairs through the multiplier's fixed latency and writes each FP32 result into the C result buffer, row-major.
- Sits between the A/B operand muxes (driven by its select outputs) and the C buffer write port.

Parameters:
- N, 4, matrix dimension (rows of A = columns of B = C dimension); legal range 1..64.
- LAT, 5, multiplier latency: pair presented with vec_valid in cycle t has its result on mult_result in cycle t+LAT; legal range 1..16.
- IDXW, ($clog2(N) > 0 ? $clog2(N) : 1), index width.

Ports:
- clk  in  1  sole clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a full N x N product; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the done cycle inclusive.
- done  out  1  one-cycle pulse in the cycle after the last C write.
- a_row_sel  out  IDXW  row of A for the vectorA mux.
- b_col_sel  out  IDXW  column of B for the vectorB mux.
- vec_valid  out  1  selects valid this cycle.
- mult_result  in  32  FP32 dot-product result from the multiplier.
- c_wr_en  out  1  C buffer write strobe.
- c_wr_row  out  IDXW  C row index.
- c_wr_col  out  IDXW  C column index.
- c_wr_data  out  32  FP32 value written.
- nan_flag  out  1  sticky; set if any written result is NaN.

Behaviour:
- All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE and the delay line is cleared.
- States and transitions:
  - IDLE: start=1 moves to ISSUE, clears the i/j counters, and clears nan_flag.
  - ISSUE: vec_valid=1 every cycle with a_row_sel=i, b_col_sel=j. j increments fastest; at j=N-1, j wraps to 0 and i increments. When the pair (N-1,N-1) is issued, move to DRAIN.
  - DRAIN: vec_valid=0, selects hold their last value. When the delay line is empty and the final write has occurred, move to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Tag delay line has LAT stages carrying {valid,row,col}.
  - When a tag exits in cycle t+LAT, the sequencer registers c_wr_data <= mult_result together with that row/col.
  - c_wr_en is therefore high in cycle t+LAT+1.
- Timing from start accepted at cycle 0:
  - vec_valid is high for cycles 1..N*N.
  - Writes occur in cycles LAT+2 .. N*N+LAT+1.
  - done is at cycle N*N+LAT+2.
- Exactly N*N writes per run, in row-major order, with no gaps or duplicates.
- NaN detection: exponent field [30:23] all ones and mantissa [22:0] nonzero, sign ignored. Inf and denormals do not set nan_flag.
  - nan_flag goes high in the same cycle as the c_wr_en carrying the NaN value.
  - It stays high until the next accepted start or rst.
- start while busy (including the done cycle) is ignored with no side effects. Earliest restart is the cycle after done.
- rst mid-run: at the next edge all outputs are 0 and in-flight tags are discarded. No further writes and no done for the aborted run.
- rst and start high together: rst wins, and start is not accepted.
- No back-pressure exists: the C buffer must accept one write per cycle.

Decomposition:
- Shared package fp32_matmul_pkg holds:
  - FSM state encoding (IDLE, ISSUE, DRAIN, DONE).
  - FP32 field constants (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22).
  - is_nan function.
- One sub-module: fp32_tag_delay_line, a parameterised LAT-stage shift register of {valid,row,col} with synchronous clear on rst.

Test Plan:
1. N=4, LAT=5, start pulsed at cycle 0; multiplier model returns 0x3F800000+(i*4+j) -> vec_valid cycles 1..16; 16 writes cycles 7..22 in order (0,0),(0,1)..(3,3) with matching data; done at cycle 23 only; busy cycles 1..23.
2. Model returns 0x7FC00000 for pair (2,1) and 0x7F800000 for (3,0) -> nan_flag rises at cycle 16 (write of (2,1)), remains high; next accepted start clears it.
3. rst asserted at cycle 10 of a run -> cycle 11: all outputs 0, FSM IDLE; no c_wr_en or done afterwards; a fresh start then completes normally per scenario 1 timing.
4. start re-pulsed at cycles 5 and 23 (done cycle) -> both ignored; start at cycle 24 accepted, vec_valid at cycle 25.
5. N=1, LAT=1: start at cycle 0 -> vec_valid cycle 1 (sel 0,0), single write cycle 3, done cycle 4.
6. rst and start high together in IDLE -> not accepted; busy stays 0 the next cycle.

Source files
------------

// File: rtl/fp32_matmul_pkg.sv
`default_nettype none
// ============================================================================
// fp32_matmul_pkg
// Shared FSM encoding, FP32 field constants and NaN classifier for the
// FP32 matrix-product sequencer.
// Revision: 1.0
// ============================================================================
package fp32_matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    localparam logic [31:0] EXP_MASK = ((32'd1 << (EXP_MSB - EXP_LSB + 1)) - 32'd1) << EXP_LSB;
    localparam logic [31:0] MAN_MASK = (32'd1 << (MAN_MSB + 1)) - 32'd1;

    // Sign is masked off first so both quiet and signalling NaNs of either sign match.
    function automatic logic is_nan(input logic [31:0] value);
        logic [31:0] mag;
        mag = value & ~(32'd1 << SIGN_BIT);
        return ((mag & EXP_MASK) == EXP_MASK) && ((mag & MAN_MASK) != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_matmul_sequencer_if.sv
`default_nettype none
// ============================================================================
// fp32_matmul_sequencer_if
// Control, operand-select, multiplier-result and C-write bundle.
// Revision: 1.0
// ============================================================================
interface fp32_matmul_sequencer_if #(
    parameter int IDXW = 2
);
    logic            start;
    logic            busy;
    logic            done;
    logic [IDXW-1:0] a_row_sel;
    logic [IDXW-1:0] b_col_sel;
    logic            vec_valid;
    logic [31:0]     mult_result;
    logic            c_wr_en;
    logic [IDXW-1:0] c_wr_row;
    logic [IDXW-1:0] c_wr_col;
    logic [31:0]     c_wr_data;
    logic            nan_flag;

    modport master (
        input  start,
        input  mult_result,
        output busy,
        output done,
        output a_row_sel,
        output b_col_sel,
        output vec_valid,
        output c_wr_en,
        output c_wr_row,
        output c_wr_col,
        output c_wr_data,
        output nan_flag
    );

    modport slave (
        output start,
        output mult_result,
        input  busy,
        input  done,
        input  a_row_sel,
        input  b_col_sel,
        input  vec_valid,
        input  c_wr_en,
        input  c_wr_row,
        input  c_wr_col,
        input  c_wr_data,
        input  nan_flag
    );
endinterface
`default_nettype wire

// File: rtl/fp32_tag_delay_line.sv
`default_nettype none
// ============================================================================
// fp32_tag_delay_line
// LAT-stage shift register of {valid,row,col} tags matching multiplier latency.
// Revision: 1.0
// ============================================================================
module fp32_tag_delay_line #(
    parameter int LAT  = 5,
    parameter int IDXW = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            push_valid,
    input  wire logic [IDXW-1:0] push_row,
    input  wire logic [IDXW-1:0] push_col,
    output logic                 tail_valid,
    output logic [IDXW-1:0]      tail_row,
    output logic [IDXW-1:0]      tail_col,
    output logic                 occupied
);

    logic [LAT-1:0]  r_valid;
    logic [IDXW-1:0] r_row [LAT];
    logic [IDXW-1:0] r_col [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_row[k] <= '0;
                r_col[k] <= '0;
            end
        end else begin
            r_valid[0] <= push_valid;
            r_row[0]   <= push_row;
            r_col[0]   <= push_col;
            for (int k = 1; k < LAT; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_row[k]   <= r_row[k-1];
                r_col[k]   <= r_col[k-1];
            end
        end
    end

    assign tail_valid = r_valid[LAT-1];
    assign tail_row   = r_row[LAT-1];
    assign tail_col   = r_col[LAT-1];
    assign occupied   = |r_valid;

endmodule
`default_nettype wire

// File: rtl/fp32_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// fp32_matmul_sequencer
// Issues all N x N (row, column) pairs to a pipelined dot-product unit and
// writes each returned result into the C buffer in row-major order.
// Revision: 1.0
// ============================================================================
module fp32_matmul_sequencer
    import fp32_matmul_pkg::*;
#(
    parameter int N    = 4,
    parameter int LAT  = 5,
    parameter int IDXW = ($clog2(N) > 0 ? $clog2(N) : 1)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    fp32_matmul_sequencer_if.master bus
);

    localparam logic [IDXW-1:0] c_IDX_LAST = IDXW'(N - 1);

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic [IDXW-1:0] r_a_sel;
    logic [IDXW-1:0] r_b_sel;
    logic            r_vec_valid;
    logic            r_wr_en;
    logic [IDXW-1:0] r_wr_row;
    logic [IDXW-1:0] r_wr_col;
    logic [31:0]     r_wr_data;
    logic            r_nan;

    logic            w_tail_valid;
    logic [IDXW-1:0] w_tail_row;
    logic [IDXW-1:0] w_tail_col;
    logic            w_tags_pending;

    fp32_tag_delay_line #(
        .LAT  (LAT),
        .IDXW (IDXW)
    ) u_tags (
        .clk        (clk),
        .rst        (rst),
        .push_valid (r_vec_valid),
        .push_row   (r_a_sel),
        .push_col   (r_b_sel),
        .tail_valid (w_tail_valid),
        .tail_row   (w_tail_row),
        .tail_col   (w_tail_col),
        .occupied   (w_tags_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_a_sel     <= '0;
            r_b_sel     <= '0;
            r_vec_valid <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_wr_data   <= '0;
            r_nan       <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= w_tail_valid;
            // The tag leaving the delay line lines up with this cycle's multiplier output.
            if (w_tail_valid) begin
                r_wr_row  <= w_tail_row;
                r_wr_col  <= w_tail_col;
                r_wr_data <= bus.mult_result;
                if (is_nan(bus.mult_result)) begin
                    r_nan <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_ISSUE;
                        r_busy      <= 1'b1;
                        r_vec_valid <= 1'b1;
                        r_a_sel     <= '0;
                        r_b_sel     <= '0;
                        r_nan       <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (r_a_sel == c_IDX_LAST && r_b_sel == c_IDX_LAST) begin
                        r_vec_valid <= 1'b0;
                        r_state     <= ST_DRAIN;
                    end else if (r_b_sel == c_IDX_LAST) begin
                        r_b_sel <= '0;
                        r_a_sel <= r_a_sel + 1'b1;
                    end else begin
                        r_b_sel <= r_b_sel + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The final write is always the (N-1,N-1) element.
                    if (!w_tags_pending && r_wr_en &&
                        r_wr_row == c_IDX_LAST && r_wr_col == c_IDX_LAST) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.a_row_sel = r_a_sel;
    assign bus.b_col_sel = r_b_sel;
    assign bus.vec_valid = r_vec_valid;
    assign bus.c_wr_en   = r_wr_en;
    assign bus.c_wr_row  = r_wr_row;
    assign bus.c_wr_col  = r_wr_col;
    assign bus.c_wr_data = r_wr_data;
    assign bus.nan_flag  = r_nan;

endmodule
`default_nettype wire

// File: tb/tb_fp32_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fp32_matmul_sequencer
// Directed bench: N=4/LAT=5 instance plus an N=1/LAT=1 instance.
// Revision: 1.0
// ============================================================================
module tb_fp32_matmul_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   nan_mode = 1'b0;

    always #5 clk = ~clk;

    fp32_matmul_sequencer_if #(.IDXW(2)) bus4 ();
    fp32_matmul_sequencer_if #(.IDXW(1)) bus1 ();

    fp32_matmul_sequencer #(.N(4), .LAT(5), .IDXW(2)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    fp32_matmul_sequencer #(.N(1), .LAT(1), .IDXW(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    function automatic logic [31:0] model_val(input logic [1:0] r, input logic [1:0] c, input bit nm);
        if (nm && r == 2'd2 && c == 2'd1) return 32'h7FC0_0000;
        if (nm && r == 2'd3 && c == 2'd0) return 32'h7F80_0000;
        return 32'h3F80_0000 + {28'd0, r, c};
    endfunction

    // Multiplier model: a pair seen in cycle t returns its result in cycle t+LAT.
    logic [4:0] m4_pipe [5];
    always @(posedge clk) begin
        for (int k = 4; k > 0; k--) m4_pipe[k] <= m4_pipe[k-1];
        m4_pipe[0] <= {bus4.vec_valid, bus4.a_row_sel, bus4.b_col_sel};
    end
    assign bus4.mult_result = model_val(m4_pipe[4][3:2], m4_pipe[4][1:0], nan_mode);

    logic m1_v;
    always @(posedge clk) m1_v <= bus1.vec_valid;
    assign bus1.mult_result = m1_v ? 32'h4049_0FDB : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int w, input bit nm);
        int row;
        int col;
        row = w / 4;
        col = w % 4;
        if (nm && row == 2 && col == 1) return 32'h7FC0_0000;
        if (nm && row == 3 && col == 0) return 32'h7F80_0000;
        return 32'h3F80_0000 + w;
    endfunction

    // Pulses start in cycle 0, then checks cycles 1..last. Optional rst in
    // cycle rst_at, extra start pulses, and a restart cycle for re-basing.
    task automatic run4(input string pfx, input bit nm, input int rst_at,
                        input int p1, input int p2, input int restart, input int last);
        int k;
        int w;
        logic ev, ew, ed, eb, en;
        int ea, ebs, er, ec;
        logic [31:0] edat;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            k  = (restart > 0 && c > restart) ? c - restart : c;
            ev = (k >= 1 && k <= 16);
            ew = (k >= 7 && k <= 22);
            ed = (k == 23);
            eb = (k >= 1 && k <= 23);
            en = nm && (k >= 16);
            ea = ev ? (k - 1) / 4 : 3;
            ebs = ev ? (k - 1) % 4 : 3;
            w  = k - 7;
            er = ew ? w / 4 : 0;
            ec = ew ? w % 4 : 0;
            edat = ew ? exp_data(w, nm) : 32'h0;
            if (rst_at > 0 && c > rst_at) begin
                ev = 1'b0; ew = 1'b0; ed = 1'b0; eb = 1'b0; en = 1'b0;
                ea = 0; ebs = 0; er = 0; ec = 0; edat = 32'h0;
            end
            check($sformatf("%s c%0d vec_valid", pfx, c), {31'd0, bus4.vec_valid}, {31'd0, ev});
            check($sformatf("%s c%0d c_wr_en", pfx, c), {31'd0, bus4.c_wr_en}, {31'd0, ew});
            check($sformatf("%s c%0d done", pfx, c), {31'd0, bus4.done}, {31'd0, ed});
            check($sformatf("%s c%0d busy", pfx, c), {31'd0, bus4.busy}, {31'd0, eb});
            check($sformatf("%s c%0d nan_flag", pfx, c), {31'd0, bus4.nan_flag}, {31'd0, en});
            if (k >= 1) begin
                check($sformatf("%s c%0d a_row_sel", pfx, c), {30'd0, bus4.a_row_sel}, ea);
                check($sformatf("%s c%0d b_col_sel", pfx, c), {30'd0, bus4.b_col_sel}, ebs);
            end
            if (ew || (rst_at > 0 && c > rst_at)) begin
                check($sformatf("%s c%0d c_wr_row", pfx, c), {30'd0, bus4.c_wr_row}, er);
                check($sformatf("%s c%0d c_wr_col", pfx, c), {30'd0, bus4.c_wr_col}, ec);
                check($sformatf("%s c%0d c_wr_data", pfx, c), bus4.c_wr_data, edat);
            end
            bus4.start = (c == p1 || c == p2 || c == restart);
            rst        = (rst_at > 0 && c == rst_at);
            tick();
        end
        bus4.start = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus4.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) tick();
        check("reset busy", {31'd0, bus4.busy}, 32'd0);
        check("reset vec_valid", {31'd0, bus4.vec_valid}, 32'd0);
        check("reset c_wr_en", {31'd0, bus4.c_wr_en}, 32'd0);
        check("reset done", {31'd0, bus4.done}, 32'd0);
        check("reset nan_flag", {31'd0, bus4.nan_flag}, 32'd0);
        check("reset a_row_sel", {30'd0, bus4.a_row_sel}, 32'd0);
        check("reset c_wr_data", bus4.c_wr_data, 32'd0);
        check("reset n1 busy", {31'd0, bus1.busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Plain full run.
        nan_mode = 1'b0;
        run4("s1", 1'b0, 0, 0, 0, 0, 24);

        // NaN at (2,1), Inf at (3,0).
        nan_mode = 1'b1;
        run4("s2", 1'b1, 0, 0, 0, 0, 24);
        check("s2 nan sticky after run", {31'd0, bus4.nan_flag}, 32'd1);

        // Abort with rst in cycle 10; start clears the flag first.
        nan_mode = 1'b0;
        run4("s3", 1'b0, 10, 0, 0, 0, 30);

        // Start pulses while busy and in the done cycle are ignored; cycle 24 restarts.
        run4("s4", 1'b0, 0, 5, 23, 24, 48);

        // rst and start together.
        rst        = 1'b1;
        bus4.start = 1'b1;
        tick();
        rst        = 1'b0;
        bus4.start = 1'b0;
        check("s6 busy after rst+start", {31'd0, bus4.busy}, 32'd0);
        check("s6 vec_valid after rst+start", {31'd0, bus4.vec_valid}, 32'd0);
        tick();
        check("s6 busy next cycle", {31'd0, bus4.busy}, 32'd0);

        // N=1, LAT=1.
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("s5 c%0d vec_valid", c), {31'd0, bus1.vec_valid}, {31'd0, (c == 1)});
            check($sformatf("s5 c%0d c_wr_en", c), {31'd0, bus1.c_wr_en}, {31'd0, (c == 3)});
            check($sformatf("s5 c%0d done", c), {31'd0, bus1.done}, {31'd0, (c == 4)});
            check($sformatf("s5 c%0d busy", c), {31'd0, bus1.busy}, {31'd0, (c >= 1 && c <= 4)});
            check($sformatf("s5 c%0d sel", c), {30'd0, bus1.a_row_sel, bus1.b_col_sel}, 32'd0);
            if (c == 3) begin
                check("s5 c_wr_data", bus1.c_wr_data, 32'h4049_0FDB);
                check("s5 c_wr_rowcol", {30'd0, bus1.c_wr_row, bus1.c_wr_col}, 32'd0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
